btb_assoc: RTL

- Parametrised set-associative, tagged branch target buffer. Successor to the direct-mapped, untagged BTB.
- Sits beside the IF-stage PC mux. It is looked up with the fetch PC and returns a registered hit/taken/target prediction one cycle later.
- It is updated from EX with resolved branch outcomes. Each entry holds a saturating direction counter, and replacement is tree-PLRU.

---
 rtl/btb_pkg.sv | 83 ++++++++
 rtl/btb_assoc_if.sv | 34 +++
 rtl/btb_plru.sv | 36 +++
 rtl/btb_assoc.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer.
//
// Holds the default geometry, the per-entry storage record, the saturating
// direction-counter step and the tree-PLRU touch/victim helpers. The entry
// record, counter type and PLRU vector are sized from the localparams below.
// An instance of btb_assoc with a different geometry needs these values
// changed to match.
//
// PLRU tree layout: node 0 is the root; node n has children 2n+1 (lower
// ways) and 2n+2 (upper ways). A node bit of 0 means "victim is on the lower
// side", 1 means "victim is on the upper side".
package btb_pkg;

    localparam int BTB_NUM_SETS   = 64;
    localparam int BTB_NUM_WAYS   = 2;
    localparam int BTB_CTR_WIDTH  = 2;
    localparam int BTB_IDX_OFFSET = 2;
    localparam int BTB_IDX_WIDTH  = $clog2(BTB_NUM_SETS);
    localparam int BTB_TAG_WIDTH  = 32 - BTB_IDX_OFFSET - BTB_IDX_WIDTH;
    localparam int BTB_WAY_WIDTH  = (BTB_NUM_WAYS > 1) ? $clog2(BTB_NUM_WAYS) : 1;
    localparam int BTB_PLRU_BITS  = (BTB_NUM_WAYS > 1) ? (BTB_NUM_WAYS - 1) : 1;

    typedef logic [BTB_CTR_WIDTH-1:0] ctr_t;
    typedef logic [BTB_WAY_WIDTH-1:0] way_t;
    typedef logic [BTB_PLRU_BITS-1:0] plru_t;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_WIDTH-1:0] tag;
        logic [31:0]              target;
        ctr_t                     ctr;
    } btb_entry_t;

    // Saturation is tested before stepping, so the counter never wraps.
    function automatic ctr_t ctr_next(ctr_t ctr, logic taken);
        ctr_t res;
        res = ctr;
        if (taken) begin
            if (!(&ctr)) res = ctr + ctr_t'(1);
        end else begin
            if (|ctr) res = ctr - ctr_t'(1);
        end
        return res;
    endfunction

    // Walk root to leaf along the touched way and point every node on the
    // path at the opposite subtree. Shifts are used instead of bit selects
    // so the same code works for any tree depth.
    function automatic plru_t plru_touch(plru_t bits, way_t way);
        plru_t res;
        int    node;
        logic  dir;
        res  = bits;
        node = 0;
        if (BTB_NUM_WAYS > 1) begin
            for (int lvl = BTB_WAY_WIDTH - 1; lvl >= 0; lvl--) begin
                dir  = 1'(way >> lvl);
                res  = (res & ~(plru_t'(1) << node)) | (plru_t'(~dir) << node);
                node = 2 * node + 1 + int'(dir);
            end
        end
        return res;
    endfunction

    // Follow the node bits from the root; each bit chosen becomes the next
    // way-number bit, most significant first.
    function automatic way_t plru_victim(plru_t bits);
        way_t way;
        int   node;
        logic dir;
        way  = '0;
        node = 0;
        if (BTB_NUM_WAYS > 1) begin
            for (int lvl = BTB_WAY_WIDTH - 1; lvl >= 0; lvl--) begin
                dir  = 1'(bits >> node);
                way  = way_t'({way, dir});
                node = 2 * node + 1 + int'(dir);
            end
        end
        return way;
    endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch/execute-side bundle of the branch target buffer.
//
// master (pipeline side): drives en, lkp_valid/lkp_pc (IF-stage lookup),
//   upd_valid/upd_pc/upd_taken/upd_target (EX-stage resolution) and flush;
//   receives the registered prediction pred_hit/pred_taken/pred_target/
//   pred_ctr.
// slave (BTB side): the mirror image.
interface btb_assoc_if;
    import btb_pkg::*;

    logic        en;
    logic        lkp_valid;
    logic [31:0] lkp_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    ctr_t        pred_ctr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;

    modport master (
        output en, lkp_valid, lkp_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        input  pred_hit, pred_taken, pred_target, pred_ctr
    );

    modport slave (
        input  en, lkp_valid, lkp_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        output pred_hit, pred_taken, pred_target, pred_ctr
    );

endinterface

// File: rtl/btb_plru.sv
// Tree-PLRU next-state for one set.
//
// bits_i            : current PLRU bits of the set
// touch_lkp_valid_i : apply a touch for a lookup hit in this set
// touch_lkp_way_i   : way hit by the lookup
// touch_upd_valid_i : apply a touch for an update in this set
// touch_upd_way_i   : way written/updated by the update
// bits_o            : bits after both touches
// victim_way_o      : replacement victim derived from bits_i
//
// The update touch is applied after the lookup touch, so it owns any node
// that both paths cross.
module btb_plru
    import btb_pkg::*;
(
    input  plru_t bits_i,
    input  logic  touch_lkp_valid_i,
    input  way_t  touch_lkp_way_i,
    input  logic  touch_upd_valid_i,
    input  way_t  touch_upd_way_i,
    output plru_t bits_o,
    output way_t  victim_way_o
);

    plru_t after_lkp;

    always_comb begin
        after_lkp = bits_i;
        if (touch_lkp_valid_i) after_lkp = plru_touch(bits_i, touch_lkp_way_i);
        bits_o = after_lkp;
        if (touch_upd_valid_i) bits_o = plru_touch(after_lkp, touch_upd_way_i);
    end

    assign victim_way_o = plru_victim(bits_i);

endmodule

// File: rtl/btb_assoc.sv
// Set-associative, tagged branch target buffer with saturating direction
// counters and tree-PLRU replacement.
//
// clk : clock
// rst : synchronous, active-low reset (clears valids, PLRU and outputs)
// bus : btb_assoc_if.slave -- lookup request, registered prediction,
//       resolved-branch update, clock enable and flush.
//
// A lookup is tag-compared against the array contents before the edge and
// the result is registered, so a same-cycle update or flush is never seen by
// the lookup that shares its edge.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int NUM_SETS   = BTB_NUM_SETS,
    parameter int NUM_WAYS   = BTB_NUM_WAYS,
    parameter int CTR_WIDTH  = BTB_CTR_WIDTH,
    parameter int IDX_OFFSET = BTB_IDX_OFFSET
) (
    input logic        clk,
    input logic        rst,
    btb_assoc_if.slave bus
);

    localparam int   IDX_WIDTH      = $clog2(NUM_SETS);
    localparam int   TAG_WIDTH      = 32 - IDX_OFFSET - IDX_WIDTH;
    localparam ctr_t CTR_WEAK_TAKEN = ctr_t'(1) << (CTR_WIDTH - 1);

    typedef logic [IDX_WIDTH-1:0] idx_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;

    btb_entry_t entry_q [NUM_SETS][NUM_WAYS];
    btb_entry_t entry_d [NUM_SETS][NUM_WAYS];
    plru_t      plru_q  [NUM_SETS];
    plru_t      plru_d  [NUM_SETS];

    logic        pred_hit_q,    pred_hit_d;
    logic        pred_taken_q,  pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;
    ctr_t        pred_ctr_q,    pred_ctr_d;

    idx_t lkp_idx, upd_idx;
    tag_t lkp_tag, upd_tag;

    logic [NUM_WAYS-1:0] lkp_match;
    logic                lkp_hit;
    way_t                lkp_way;
    logic                upd_hit;
    way_t                upd_way;
    logic                upd_free;
    way_t                upd_free_way;
    way_t                plru_victim_way;
    way_t                upd_alloc_way;
    logic                lkp_touch;
    logic                upd_touch;
    plru_t               plru_upd_bits;
    logic                unused_pc_bits;

    assign lkp_idx = bus.lkp_pc[IDX_OFFSET +: IDX_WIDTH];
    assign lkp_tag = bus.lkp_pc[31 -: TAG_WIDTH];
    assign upd_idx = bus.upd_pc[IDX_OFFSET +: IDX_WIDTH];
    assign upd_tag = bus.upd_pc[31 -: TAG_WIDTH];

    assign unused_pc_bits = ^{bus.lkp_pc[IDX_OFFSET-1:0], bus.upd_pc[IDX_OFFSET-1:0]};

    // Lookup tag compare. At most one way can match because allocation only
    // happens on a miss in the same set.
    always_comb begin
        lkp_match = '0;
        lkp_hit   = 1'b0;
        lkp_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            lkp_match[w] = entry_q[lkp_idx][w].valid && (entry_q[lkp_idx][w].tag == lkp_tag);
            if (lkp_match[w]) begin
                lkp_hit = 1'b1;
                lkp_way = way_t'(w);
            end
        end
    end

    // Update tag compare plus the lowest-numbered invalid way; the downward
    // scan lets the lowest free way overwrite any higher one.
    always_comb begin
        upd_hit      = 1'b0;
        upd_way      = '0;
        upd_free     = 1'b0;
        upd_free_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (entry_q[upd_idx][w].valid && (entry_q[upd_idx][w].tag == upd_tag)) begin
                upd_hit = 1'b1;
                upd_way = way_t'(w);
            end
            if (!entry_q[upd_idx][w].valid) begin
                upd_free     = 1'b1;
                upd_free_way = way_t'(w);
            end
        end
    end

    assign lkp_touch     = bus.en && bus.lkp_valid && lkp_hit;
    assign upd_touch     = bus.en && bus.upd_valid && !bus.flush && (upd_hit || bus.upd_taken);
    assign upd_alloc_way = upd_free ? upd_free_way : plru_victim_way;

    // The single PLRU instance serves the update's set; a lookup hit in the
    // same set is folded in here so the update's touch wins conflicts.
    btb_plru u_plru (
        .bits_i            (plru_q[upd_idx]),
        .touch_lkp_valid_i (lkp_touch && (lkp_idx == upd_idx)),
        .touch_lkp_way_i   (lkp_way),
        .touch_upd_valid_i (upd_touch),
        .touch_upd_way_i   (upd_hit ? upd_way : upd_alloc_way),
        .bits_o            (plru_upd_bits),
        .victim_way_o      (plru_victim_way)
    );

    // Next state: everything holds unless en is high. Flush wins over the
    // update; the lookup result is always taken from the pre-edge array.
    always_comb begin
        entry_d       = entry_q;
        plru_d        = plru_q;
        pred_hit_d    = pred_hit_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        pred_ctr_d    = pred_ctr_q;

        if (bus.en) begin
            pred_hit_d    = 1'b0;
            pred_taken_d  = 1'b0;
            pred_target_d = '0;
            pred_ctr_d    = '0;
            if (bus.lkp_valid && lkp_hit) begin
                pred_hit_d    = 1'b1;
                pred_ctr_d    = entry_q[lkp_idx][lkp_way].ctr;
                pred_taken_d  = entry_q[lkp_idx][lkp_way].ctr[CTR_WIDTH-1];
                pred_target_d = entry_q[lkp_idx][lkp_way].target;
            end

            if (lkp_touch) plru_d[lkp_idx] = plru_touch(plru_q[lkp_idx], lkp_way);
            if (upd_touch) plru_d[upd_idx] = plru_upd_bits;

            if (bus.flush) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        entry_d[s][w].valid = 1'b0;
                    end
                end
            end else if (bus.upd_valid) begin
                if (upd_hit) begin
                    entry_d[upd_idx][upd_way].ctr = ctr_next(entry_q[upd_idx][upd_way].ctr, bus.upd_taken);
                    if (bus.upd_taken) entry_d[upd_idx][upd_way].target = bus.upd_target;
                end else if (bus.upd_taken) begin
                    entry_d[upd_idx][upd_alloc_way].valid  = 1'b1;
                    entry_d[upd_idx][upd_alloc_way].tag    = upd_tag;
                    entry_d[upd_idx][upd_alloc_way].target = bus.upd_target;
                    entry_d[upd_idx][upd_alloc_way].ctr    = CTR_WEAK_TAKEN;
                end
            end
        end
    end

    // Tags, targets and counters need no reset: they are ignored until the
    // matching valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    entry_q[s][w].valid <= 1'b0;
                end
                plru_q[s] <= '0;
            end
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_ctr_q    <= '0;
        end else begin
            entry_q       <= entry_d;
            plru_q        <= plru_d;
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            pred_ctr_q    <= pred_ctr_d;
        end
    end

    assign bus.pred_hit    = pred_hit_q;
    assign bus.pred_taken  = pred_taken_q;
    assign bus.pred_target = pred_target_q;
    assign bus.pred_ctr    = pred_ctr_q;

endmodule
